// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the parametrised register file.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default width, address width, read ports.
//   rf_depth(addr_w)                  : number of registers for a given address width.
package regfile_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NUM_RD = 2;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: write/reserve/read bundle between decode/writeback and the register file.
//   we, rd_in, data   : write port (accepted on every rising edge with we=1).
//   rsv_en, rsv_addr  : reservation port (marks a register busy).
//   rs_in             : packed read addresses, port k at [k*ADDR_W +: ADDR_W].
//   rs_out, rs_busy   : packed read data (port k at [k*DATA_W +: DATA_W]) and busy flags.
// Handshake: none. Every request presented at a rising edge is accepted on that
// edge; there is no valid/ready pair and the file never stalls its users.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
) ();

  logic                     we;
  logic [ADDR_W-1:0]        rd_in;
  logic [DATA_W-1:0]        data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD*ADDR_W-1:0] rs_in;
  logic [NUM_RD*DATA_W-1:0] rs_out;
  logic [NUM_RD-1:0]        rs_busy;

  // Pipeline side: drives requests, observes read results.
  modport master (
    output we, rd_in, data, rsv_en, rsv_addr, rs_in,
    input  rs_out, rs_busy
  );

  // Register file side.
  modport slave (
    input  we, rd_in, data, rsv_en, rsv_addr, rs_in,
    output rs_out, rs_busy
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   i_rst                        : forces zero data / not-busy while reset is held.
//   i_addr                       : register being read.
//   i_regs, i_busy               : storage and scoreboard from the top level.
//   i_we, i_wr_addr, i_wr_data   : same-cycle write, used for forwarding.
//   i_rsv_en, i_rsv_addr         : same-cycle reservation, only affects forwarded busy.
//   o_data, o_busy               : read result for this port.
module regfile_read_port #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_regs [DEPTH],
  input  logic [DEPTH-1:0]  i_busy,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  // Later assignments take priority: reset, then zero register, then bypass.
  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if (BYPASS && i_we && (i_wr_addr == i_addr)) begin
      // The write clears busy at the edge; only a reservation landing on the
      // same edge (a newer producer) keeps the register busy.
      o_data = i_wr_data;
      o_busy = i_rsv_en && (i_rsv_addr == i_addr);
    end
    if (ZERO_REG && (i_addr == '0)) begin
      o_data = '0;
      o_busy = 1'b0;
    end
    // The bypass path would otherwise leak write data through during reset.
    if (i_rst) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-read, single-write register file with a
// per-register busy scoreboard, optional hard-wired zero register and optional
// write-to-read forwarding.
//   clk : rising-edge clock.
//   rst : asynchronous active-high reset; clears all registers and busy bits.
//   bus : regfile_if slave (write port, reservation port, NUM_RD read ports).
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic w_wr_ok;
  logic w_rsv_ok;

  // Address 0 is read-only when the zero register is enabled.
  assign w_wr_ok  = bus.we     && !(ZERO_REG && (bus.rd_in    == '0));
  assign w_rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == '0));

  // The reservation is written after the write so that a write and a
  // reservation to the same register leave it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[bus.rd_in] <= bus.data;
        r_busy[bus.rd_in] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  logic [NUM_RD*DATA_W-1:0] w_rs_out;
  logic [NUM_RD-1:0]        w_rs_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .i_rst      (rst),
      .i_addr     (bus.rs_in[k*ADDR_W +: ADDR_W]),
      .i_regs     (r_regs),
      .i_busy     (r_busy),
      .i_we       (bus.we),
      .i_wr_addr  (bus.rd_in),
      .i_wr_data  (bus.data),
      .i_rsv_en   (bus.rsv_en),
      .i_rsv_addr (bus.rsv_addr),
      .o_data     (w_rs_out[k*DATA_W +: DATA_W]),
      .o_busy     (w_rs_busy[k])
    );
  end

  assign bus.rs_out  = w_rs_out;
  assign bus.rs_busy = w_rs_busy;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench for regfile_param over four configurations:
//   u0 default sizes, BYPASS=0     u1 default sizes, BYPASS=1
//   u2 ZERO_REG=1, BYPASS=1        u3 DATA_W=16, ADDR_W=4, NUM_RD=3, BYPASS=0
module tb_regfile_param;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) bus0 ();
  regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) bus1 ();
  regfile_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(2)) bus2 ();
  regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3)) bus3 ();

  regfile_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b1))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  regfile_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(bus2));
  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0))
    u3 (.clk(clk), .rst(rst), .bus(bus3));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns 1 time unit after the rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    bus0.we = 0; bus0.rd_in = '0; bus0.data = '0; bus0.rsv_en = 0; bus0.rsv_addr = '0; bus0.rs_in = '0;
    bus1.we = 0; bus1.rd_in = '0; bus1.data = '0; bus1.rsv_en = 0; bus1.rsv_addr = '0; bus1.rs_in = '0;
    bus2.we = 0; bus2.rd_in = '0; bus2.data = '0; bus2.rsv_en = 0; bus2.rsv_addr = '0; bus2.rs_in = '0;
    bus3.we = 0; bus3.rd_in = '0; bus3.data = '0; bus3.rsv_en = 0; bus3.rsv_addr = '0; bus3.rs_in = '0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [7:0] d);
    bus0.we = 1; bus0.rd_in = a; bus0.data = d;
    tick();
    bus0.we = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Reset is asserted from time 0.
    #1;
    checks++;
    if (bus0.rs_out !== 16'h0000 || bus0.rs_busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_initial: got out=%h busy=%b expected 0000/00", bus0.rs_out, bus0.rs_busy);
    end
    tick();
    rst = 0;
    // r1 = AA and reserved on the same edge.
    bus0.we = 1; bus0.rd_in = 3'd1; bus0.data = 8'hAA; bus0.rsv_en = 1; bus0.rsv_addr = 3'd1;
    bus0.rs_in = {3'd1, 3'd1};
    tick();
    bus0.we = 0; bus0.rsv_en = 0;
    checks++;
    if (bus0.rs_out !== 16'hAAAA || bus0.rs_busy !== 2'b11) begin
      failures++;
      $display("FAIL reset_pre: got out=%h busy=%b expected aaaa/11", bus0.rs_out, bus0.rs_busy);
    end
    // Bypass instance holds a live write through the reset pulse.
    bus1.we = 1; bus1.rd_in = 3'd2; bus1.data = 8'h55; bus1.rs_in = {3'd2, 3'd2};
    #2 rst = 1;
    #1;
    checks++;
    if (bus0.rs_out !== 16'h0000 || bus0.rs_busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: got out=%h busy=%b expected 0000/00", bus0.rs_out, bus0.rs_busy);
    end
    checks++;
    if (bus1.rs_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_bypass: got out=%h expected 0000", bus1.rs_out);
    end
    bus1.we = 0;
    #2 rst = 0;
    tick();
    // Reset also dropped the write that was pending on u1.
    checks++;
    if (bus1.rs_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_write_dropped: got out=%h expected 0000", bus1.rs_out);
    end
  endtask

  task automatic test_write_read();
    wr0(3'd1, 8'hAA);
    wr0(3'd2, 8'hCC);
    wr0(3'd3, 8'hF0);
    bus0.rs_in = {3'd2, 3'd1};
    #1;
    checks++;
    if (bus0.rs_out[7:0] !== 8'hAA || bus0.rs_out[15:8] !== 8'hCC) begin
      failures++;
      $display("FAIL rd_r1_r2: got %h expected ccaa", bus0.rs_out);
    end
    bus0.rs_in = {3'd1, 3'd3};
    #1;
    checks++;
    if (bus0.rs_out[7:0] !== 8'hF0 || bus0.rs_out[15:8] !== 8'hAA) begin
      failures++;
      $display("FAIL rd_r3_r1: got %h expected aaf0", bus0.rs_out);
    end
    // Overwrite r1: no forwarding, old value until the edge.
    bus0.we = 1; bus0.rd_in = 3'd1; bus0.data = 8'h0F;
    #1;
    checks++;
    if (bus0.rs_out[15:8] !== 8'hAA) begin
      failures++;
      $display("FAIL no_bypass: got %h expected aa", bus0.rs_out[15:8]);
    end
    tick();
    bus0.we = 0;
    checks++;
    if (bus0.rs_out[15:8] !== 8'h0F) begin
      failures++;
      $display("FAIL overwrite_r1: got %h expected 0f", bus0.rs_out[15:8]);
    end
  endtask

  task automatic test_bypass();
    bus1.rs_in = {3'd6, 3'd5};
    bus1.we = 1; bus1.rd_in = 3'd5; bus1.data = 8'h3C;
    #1;
    checks++;
    if (bus1.rs_out[7:0] !== 8'h3C || bus1.rs_out[15:8] !== 8'h00) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h expected 003c", bus1.rs_out);
    end
    tick();
    bus1.we = 0;
    checks++;
    if (bus1.rs_out[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL bypass_stored: got %h expected 3c", bus1.rs_out[7:0]);
    end
  endtask

  task automatic test_scoreboard();
    // u0 (no forwarding)
    bus0.rs_in = {3'd0, 3'd4};
    bus0.rsv_en = 1; bus0.rsv_addr = 3'd4;
    #1;
    checks++;
    if (bus0.rs_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rsv_no_bypass: got %b expected 0", bus0.rs_busy[0]);
    end
    tick();
    bus0.rsv_en = 0;
    checks++;
    if (bus0.rs_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_set: got %b expected 1", bus0.rs_busy[0]);
    end
    bus0.we = 1; bus0.rd_in = 3'd4; bus0.data = 8'h77;
    #1;
    checks++;
    if (bus0.rs_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_edge: got %b expected 1", bus0.rs_busy[0]);
    end
    tick();
    bus0.we = 0;
    checks++;
    if (bus0.rs_busy[0] !== 1'b0 || bus0.rs_out[7:0] !== 8'h77) begin
      failures++;
      $display("FAIL write_clears: got busy=%b data=%h expected 0/77", bus0.rs_busy[0], bus0.rs_out[7:0]);
    end
    bus0.we = 1; bus0.rd_in = 3'd4; bus0.data = 8'h77; bus0.rsv_en = 1; bus0.rsv_addr = 3'd4;
    tick();
    bus0.we = 0; bus0.rsv_en = 0;
    checks++;
    if (bus0.rs_busy[0] !== 1'b1 || bus0.rs_out[7:0] !== 8'h77) begin
      failures++;
      $display("FAIL write_and_rsv: got busy=%b data=%h expected 1/77", bus0.rs_busy[0], bus0.rs_out[7:0]);
    end
    // u1 (forwarding): busy clears combinationally in the write cycle.
    bus1.rs_in = {3'd4, 3'd4};
    bus1.rsv_en = 1; bus1.rsv_addr = 3'd4;
    tick();
    bus1.rsv_en = 0;
    bus1.we = 1; bus1.rd_in = 3'd4; bus1.data = 8'h11;
    #1;
    checks++;
    if (bus1.rs_busy !== 2'b00 || bus1.rs_out !== 16'h1111) begin
      failures++;
      $display("FAIL bypass_busy_clear: got busy=%b out=%h expected 00/1111", bus1.rs_busy, bus1.rs_out);
    end
    bus1.rsv_en = 1;
    #1;
    checks++;
    if (bus1.rs_busy !== 2'b11) begin
      failures++;
      $display("FAIL bypass_busy_rsv: got %b expected 11", bus1.rs_busy);
    end
    tick();
    bus1.we = 0; bus1.rsv_en = 0;
    checks++;
    if (bus1.rs_busy !== 2'b11 || bus1.rs_out !== 16'h1111) begin
      failures++;
      $display("FAIL bypass_rsv_stored: got busy=%b out=%h expected 11/1111", bus1.rs_busy, bus1.rs_out);
    end
  endtask

  task automatic test_zero_reg();
    bus2.rs_in = {3'd1, 3'd0};
    bus2.we = 1; bus2.rd_in = 3'd0; bus2.data = 8'hFF;
    bus2.rsv_en = 1; bus2.rsv_addr = 3'd0;
    #1;
    checks++;
    if (bus2.rs_out[7:0] !== 8'h00 || bus2.rs_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_same_cycle: got data=%h busy=%b expected 00/0", bus2.rs_out[7:0], bus2.rs_busy[0]);
    end
    tick();
    bus2.we = 0; bus2.rsv_en = 0;
    checks++;
    if (bus2.rs_out[7:0] !== 8'h00 || bus2.rs_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_after: got data=%h busy=%b expected 00/0", bus2.rs_out[7:0], bus2.rs_busy[0]);
    end
    // Register 1 of the same instance behaves normally.
    bus2.we = 1; bus2.rd_in = 3'd1; bus2.data = 8'h12;
    bus2.rsv_en = 1; bus2.rsv_addr = 3'd1;
    tick();
    bus2.we = 0; bus2.rsv_en = 0;
    checks++;
    if (bus2.rs_out[15:8] !== 8'h12 || bus2.rs_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL zero_nonzero_reg: got data=%h busy=%b expected 12/1", bus2.rs_out[15:8], bus2.rs_busy[1]);
    end
  endtask

  task automatic test_wide();
    bus3.we = 1; bus3.rd_in = 4'd15; bus3.data = 16'hBEEF;
    tick();
    bus3.rd_in = 4'd14; bus3.data = 16'h1234;
    tick();
    bus3.we = 0;
    bus3.rs_in = {4'd15, 4'd15, 4'd15};
    #1;
    checks++;
    if (bus3.rs_out !== 48'hBEEF_BEEF_BEEF || bus3.rs_busy !== 3'b000) begin
      failures++;
      $display("FAIL wide_r15: got out=%h busy=%b expected beefbeefbeef/000", bus3.rs_out, bus3.rs_busy);
    end
    bus3.rs_in = {4'd0, 4'd14, 4'd15};
    #1;
    checks++;
    if (bus3.rs_out !== 48'h0000_1234_BEEF) begin
      failures++;
      $display("FAIL wide_mixed: got %h expected 00001234beef", bus3.rs_out);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1;
    idle_all();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 8×8 two-read/one-write register file. It adds configurable data width, depth and read-port count, asynchronous reset of all registers, an optional hard-wired zero register, and optional write-to-read bypass. It also carries a per-register busy scoreboard, so the issue logic can detect pending writes. It sits between decode (read addresses, reservations) and writeback (write port) in the processor datapath.

## Interface

**Parameters**
- `DATA_W`, 8, register width in bits.
- `ADDR_W`, 3, address width; depth is 2**ADDR_W.
- `NUM_RD`, 2, number of read ports (1..4).
- `ZERO_REG`, 0, when 1, register 0 always reads 0 and ignores writes and reservations.
- `BYPASS`, 1, when 1, a same-cycle write is forwarded to matching read ports.

**Ports** (one clock; reset is asynchronous and active-high)
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `we`  in  1  write enable.
- `rd_in`  in  ADDR_W  write address.
- `data`  in  DATA_W  write data.
- `rsv_en`  in  1  reserve request: marks a register busy.
- `rsv_addr`  in  ADDR_W  register to reserve.
- `rs_in`  in  NUM_RD*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
- `rs_out`  out  NUM_RD*DATA_W  packed read data; port k is at [k*DATA_W +: DATA_W].
- `rs_busy`  out  NUM_RD  per-port busy flag for the addressed register.

## Operation

**Storage and reset**
- Storage is `regs[2**ADDR_W]` × DATA_W plus `busy[2**ADDR_W]`.
- `rst` high immediately clears all regs and busy bits, independent of `clk`.
- While reset is asserted, every `rs_out` reads 0 and every `rs_busy` reads 0.
- Writes and reservations are ignored while `rst` is high.

**Write**
- On a rising edge with `we`=1: `regs[rd_in] <= data` and `busy[rd_in] <= 0`.

**Reserve**
- On a rising edge with `rsv_en`=1: `busy[rsv_addr] <= 1`.
- If a write and a reservation target the same address on the same edge, both take effect: the data is written and busy ends at 1. The reservation represents a newer producer.

**Read** (combinational, per port k, address a = rs_in[k])
- If ZERO_REG=1 and a=0: data 0, busy 0.
- Else if BYPASS=1 and `we`=1 and `rd_in`=a: data = `data`, busy = (`rsv_en` && `rsv_addr`==a).
- Else: data = regs[a], busy = busy[a].

**Zero register**
- With ZERO_REG=1, writes and reservations to address 0 are dropped.
- regs[0] and busy[0] stay 0 permanently.

**General**
- All read ports are independent; any number of them may address the same register.
- Addresses are fully decoded; there is no out-of-range case.

## Timing
- Write latency: with BYPASS=0, data is visible on reads the cycle after the write edge. With BYPASS=1, data is visible in the same cycle that `we` is asserted.
- Busy set: `rs_busy` rises the cycle after the `rsv_en` edge. There is no bypass for reservations.
- Busy clear: with BYPASS=0, busy clears the cycle after the write edge. With BYPASS=1, it clears combinationally in the write cycle.
- Reset is asynchronous on assertion. Deassertion must be synchronised externally to `clk`. The first write accepted is the edge after `rst` falls.
- No handshakes or stalls; every request is accepted on its edge.
- Read path: address-to-data is combinational (a mux plus a bypass comparator per port).

## Structure
- Package `regfile_pkg` holds the default constants (`RF_DATA_W`=8, `RF_ADDR_W`=3, `RF_NUM_RD`=2) and a function `rf_depth(addr_w)`.
- Sub-module `regfile_read_port` implements one port: the address mux, bypass compare, zero-register override and busy selection. It is instantiated NUM_RD times in a generate loop.
- The top level owns the storage arrays, the write/reserve sequential logic and the reset.

## Test plan
- **Reset:** write 0xAA to r1, then pulse `rst` mid-cycle. Both ports reading r1 return 0x00 and busy 0 before the next edge.
- **Write/read (BYPASS=0, NUM_RD=2):** write r1=0xAA, r2=0xCC, r3=0xF0.
  - Reading r1/r2 gives 0xAA/0xCC.
  - Reading r3/r1 gives 0xF0/0xAA.
  - Overwrite r1=0x0F; the port reads 0x0F on the next cycle.
- **Bypass (BYPASS=1):** hold rs0=r5 while driving `we`=1, rd=r5, data=0x3C. `rs_out[0]`=0x3C in the same cycle, before the edge.
- **Scoreboard:**
  - Reserve r4: `rs_busy` for r4 = 1 from the next cycle.
  - Write r4=0x77: busy = 0 after the edge.
  - Simultaneous write and reserve of r4: data = 0x77 and busy stays 1.
- **Zero register (ZERO_REG=1):** write 0xFF to r0 and reserve r0. Reads of r0 return 0x00 with busy 0.
- **Width/depth (DATA_W=16, ADDR_W=4, NUM_RD=3):** write r15=0xBEEF. All three ports addressing r15 return 0xBEEF.
